// File: rtl/fft_x2_butterfly.sv
// Radix-2 butterfly (twiddle W0 = 1): X0 = x0 + x1, X1 = x0 - x1 on I and Q, one-cycle latency.
// Optional macro FFT_X2_SCALE_EN: halve every sum/difference instead of saturating it.
module fft_x2_butterfly #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] in_data_i_0,
    input  logic [DATA_W-1:0] in_data_q_0,
    input  logic [DATA_W-1:0] in_data_i_1,
    input  logic [DATA_W-1:0] in_data_q_1,
    output logic [DATA_W-1:0] out_data_i_0,
    output logic [DATA_W-1:0] out_data_q_0,
    output logic [DATA_W-1:0] out_data_i_1,
    output logic [DATA_W-1:0] out_data_q_1,
    output logic              complete
);

    // Handshake: an input pair is accepted on every rising clk where valid=1 (no ready,
    // no backpressure); complete is high for exactly the cycle after each accepted pair.

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0]   sum_i, sum_q, dif_i, dif_q;
    logic [DATA_W-1:0] i0_d, q0_d, i1_d, q1_d;
    logic [DATA_W-1:0] i0_q, q0_q, i1_q, q1_q;
    logic              complete_q;

    function automatic logic [DATA_W-1:0] narrow(input logic [DATA_W:0] v);
`ifdef FFT_X2_SCALE_EN
        // Arithmetic shift right by one of a DATA_W+1-bit value always fits DATA_W bits.
        return v[DATA_W:1];
`else
        if (v[DATA_W] != v[DATA_W-1]) begin
            return v[DATA_W] ? MAX_NEG : MAX_POS;
        end
        return v[DATA_W-1:0];
`endif
    endfunction

    always_comb begin
        sum_i = {in_data_i_0[DATA_W-1], in_data_i_0} + {in_data_i_1[DATA_W-1], in_data_i_1};
        sum_q = {in_data_q_0[DATA_W-1], in_data_q_0} + {in_data_q_1[DATA_W-1], in_data_q_1};
        dif_i = {in_data_i_0[DATA_W-1], in_data_i_0} - {in_data_i_1[DATA_W-1], in_data_i_1};
        dif_q = {in_data_q_0[DATA_W-1], in_data_q_0} - {in_data_q_1[DATA_W-1], in_data_q_1};
        i0_d  = narrow(sum_i);
        q0_d  = narrow(sum_q);
        i1_d  = narrow(dif_i);
        q1_d  = narrow(dif_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i0_q       <= '0;
            q0_q       <= '0;
            i1_q       <= '0;
            q1_q       <= '0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= valid;
            if (valid) begin
                i0_q <= i0_d;
                q0_q <= q0_d;
                i1_q <= i1_d;
                q1_q <= q1_d;
            end
        end
    end

    assign out_data_i_0 = i0_q;
    assign out_data_q_0 = q0_q;
    assign out_data_i_1 = i1_q;
    assign out_data_q_1 = q1_q;
    assign complete     = complete_q;

endmodule

// File: tb/tb_fft_x2_butterfly.sv
// Scoreboard bench for fft_x2_butterfly: directed vectors push expected results, a monitor pops them.
module tb_fft_x2_butterfly;

    localparam int DATA_W = 16;
    localparam int W      = 4 * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic [DATA_W-1:0] in_data_i_0 = '0, in_data_q_0 = '0, in_data_i_1 = '0, in_data_q_1 = '0;
    logic [DATA_W-1:0] out_data_i_0, out_data_q_0, out_data_i_1, out_data_q_1;
    logic              complete;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp = '0;
    int checks = 0;
    int failures = 0;

    fft_x2_butterfly #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid),
        .in_data_i_0(in_data_i_0), .in_data_q_0(in_data_q_0),
        .in_data_i_1(in_data_i_1), .in_data_q_1(in_data_q_1),
        .out_data_i_0(out_data_i_0), .out_data_q_0(out_data_q_0),
        .out_data_i_1(out_data_i_1), .out_data_q_1(out_data_q_1),
        .complete(complete)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] outs();
        return {out_data_i_0, out_data_q_0, out_data_i_1, out_data_q_1};
    endfunction

    // driver tasks
    task automatic drive(input logic [DATA_W-1:0] x0i, x0q, x1i, x1q, input logic [W-1:0] exp);
        @(negedge clk);
        valid       = 1'b1;
        in_data_i_0 = x0i;
        in_data_q_0 = x0q;
        in_data_i_1 = x1i;
        in_data_q_1 = x1q;
        exp_q.push_back(exp);
    endtask

    task automatic idle_random();
        @(negedge clk);
        valid       = 1'b0;
        in_data_i_0 = DATA_W'($urandom_range(0, 65535));
        in_data_q_0 = DATA_W'($urandom_range(0, 65535));
        in_data_i_1 = DATA_W'($urandom_range(0, 65535));
        in_data_q_1 = DATA_W'($urandom_range(0, 65535));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            last_exp = '0;
            check("reset_outputs", outs(), '0);
            check("reset_complete", W'(complete), '0);
        end else if (complete) begin
            if (exp_q.size() == 0) begin
                check("unexpected_complete", W'(complete), '0);
            end else begin
                last_exp = exp_q.pop_front();
                check("result", outs(), last_exp);
            end
        end else begin
            check("hold", outs(), last_exp);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset mid-operation: pending result discarded, outputs clear without a clock edge
        drive(16'h1234, 16'h0567, 16'h0111, 16'h0222, {16'h1345, 16'h0789, 16'h1123, 16'h0345});
        drive(16'h0200, 16'h0300, 16'h0100, 16'h0100, {16'h0300, 16'h0400, 16'h0100, 16'h0200});
        drive(16'h0010, 16'h0020, 16'h0030, 16'h0040,
`ifdef FFT_X2_SCALE_EN
              {16'h0020, 16'h0030, 16'hFFF0, 16'hFFF0});
`else
              {16'h0040, 16'h0060, 16'hFFE0, 16'hFFE0});
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_outputs", outs(), '0);
        check("async_reset_complete", W'(complete), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;

`ifdef FFT_X2_SCALE_EN
        drive(16'h0064, 16'h0032, 16'h0014, 16'hFFF6, {16'h003C, 16'h0014, 16'h0028, 16'h001E});
        idle_random();
        repeat (2) idle_random();
        drive(16'h7FFF, 16'h0000, 16'h0001, 16'h0000, {16'h4000, 16'h0000, 16'h3FFF, 16'h0000});
        drive(16'h0000, 16'h8000, 16'h0000, 16'hFFFF, {16'h0000, 16'hBFFF, 16'h0000, 16'hC000});
        drive(16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, {16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000});
        idle_random();
        for (int k = 1; k <= 4; k++)
            drive(DATA_W'(k), 16'h0000, 16'h0000, 16'h0000,
                  {DATA_W'(k >> 1), 16'h0000, DATA_W'(k >> 1), 16'h0000});
`else
        drive(16'h0064, 16'h0032, 16'h0014, 16'hFFF6, {16'h0078, 16'h0028, 16'h0050, 16'h003C});
        idle_random();
        repeat (2) idle_random();
        drive(16'h7FFF, 16'h0000, 16'h0001, 16'h0000, {16'h7FFF, 16'h0000, 16'h7FFE, 16'h0000});
        drive(16'h0000, 16'h8000, 16'h0000, 16'hFFFF, {16'h0000, 16'h8000, 16'h0000, 16'h8001});
        drive(16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, {16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000});
        idle_random();
        for (int k = 1; k <= 4; k++)
            drive(DATA_W'(k), 16'h0000, 16'h0000, 16'h0000,
                  {DATA_W'(k), 16'h0000, DATA_W'(k), 16'h0000});
`endif
        // valid drops after the stream: complete falls next cycle, last value held
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        #1;
        check("stream_complete_drop", W'(complete), '0);
`ifdef FFT_X2_SCALE_EN
        check("stream_hold_i0", W'(out_data_i_0), W'(16'h0002));
`else
        check("stream_hold_i0", W'(out_data_i_0), W'(16'h0004));
`endif

        repeat (10) idle_random();
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", W'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
